// File: rtl/rv_sim_pkg.sv
// rtl/rv_sim_pkg.sv - shared types and constants for the RV run controller
package rv_sim_pkg;

  // Run controller states: idle, core held in reset, core running, terminal causes
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } run_state_t;

  // Exit word value that reports success
  localparam int unsigned TOHOST_PASS = 1;

  // Bit of the exit word that marks the write as an exit request
  localparam int unsigned TOHOST_EXIT_BIT = 0;

  // True for the three terminal states
  function automatic logic is_terminal(input run_state_t s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/rv_sat_counter.sv
// rtl/rv_sat_counter.sv - counter with synchronous clear that saturates at all-ones
module rv_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear has priority; increment stops once all ones is reached
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rv_run_ctrl.sv
// rtl/rv_run_ctrl.sv - core reset sequencer and tohost completion monitor
module rv_run_ctrl
  import rv_sim_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     RESET_CYCLES = 2,
  parameter int unsigned     MAX_CYCLES   = 100,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             core_rst_n,
  input  logic             dmem_we,
  input  logic [XLEN-1:0]  dmem_addr,
  input  logic [XLEN-1:0]  dmem_wdata,
  input  logic             retire,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-2:0]  exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  // Hold counter is loaded with RESET_CYCLES and the transition to RUN happens
  // on the edge where it is already zero, so core_rst_n rises RESET_CYCLES+1
  // edges after the start edge.
  localparam int unsigned       HOLD_W    = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES);

  run_state_t       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [XLEN-2:0]  exit_code_q, exit_code_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;

  logic in_run;
  logic exit_wr;
  logic exit_pass;
  logic budget_hit;
  logic cnt_en;
  logic inst_en;

  assign in_run    = (state_q == ST_RUN);
  assign exit_wr   = dmem_we && (dmem_addr == TOHOST_ADDR) && dmem_wdata[TOHOST_EXIT_BIT];
  assign exit_pass = (dmem_wdata == XLEN'(TOHOST_PASS));

  // Budget expires on the edge where cycle_count becomes MAX_CYCLES; a counter
  // pinned at all ones can never step onto it.
  assign budget_hit = (MAX_CYCLES != 0) && (cycle_count != '1) &&
                      ((64'(cycle_count) + 64'd1) == 64'(MAX_CYCLES));

  // Counters only advance in RUN; a start in the same cycle clears instead
  assign cnt_en  = in_run && !start;
  assign inst_en = cnt_en && retire;

  // Next state, hold counter, exit code and registered output values
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    exit_code_d = exit_code_q;

    if (start) begin
      state_d     = ST_HOLD;
      hold_d      = HOLD_LOAD;
      exit_code_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_d = ST_RUN;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (exit_wr) begin
            if (exit_pass) begin
              state_d = ST_PASS;
            end else begin
              state_d     = ST_FAIL;
              exit_code_d = dmem_wdata[XLEN-1:1];
            end
          end else if (budget_hit) begin
            state_d = ST_TIMEOUT;
          end
        end
        ST_PASS, ST_FAIL, ST_TIMEOUT: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    core_rst_n_d = (state_d == ST_RUN);
    busy_d       = (state_d == ST_HOLD) || (state_d == ST_RUN);
    done_d       = is_terminal(state_d);
    pass_d       = (state_d == ST_PASS);
    fail_d       = (state_d == ST_FAIL);
    timeout_d    = (state_d == ST_TIMEOUT);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      exit_code_q  <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      exit_code_q  <= exit_code_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
    end
  end

  rv_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .en    (cnt_en),
    .count (cycle_count)
  );

  rv_sat_counter #(.WIDTH(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .en    (inst_en),
    .count (instret_count)
  );

  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign exit_code  = exit_code_q;

endmodule
